instruction_encoder: RTL and testbench

Inverse of the instruction decode stage. Accepts instruction fields (format, registers, opcode, immediate) over a valid/ready handshake, range-checks them, and packs them into 32-bit instruction words. Words are tagged with an incrementing instruction-memory address and queued for the instruction-memory loader. An internal state machine can inject runs of NOP words for padding.

---
 rtl/instr_fmt_pkg.sv | 87 ++++++++
 rtl/encoder_fifo.sv | 62 ++++++
 rtl/instruction_encoder.sv | 153 +++++++++++++++
 tb/tb_instruction_encoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fmt_pkg.sv
// Instruction format definitions shared by the encoder and the decode stage.
// Holds format/error codes, fixed opcodes, the NOP word, field bit positions,
// and helper functions that range-check a field bundle and pack it into a word.
package instr_fmt_pkg;

    typedef enum logic [1:0] {
        FMT_A   = 2'd0,
        FMT_B   = 2'd1,
        FMT_C   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_FORMAT = 2'b01,
        ERR_OPCODE = 2'b10,
        ERR_RANGE  = 2'b11
    } err_e;

    localparam logic [5:0]  OPC_NOP  = 6'b111111;
    localparam logic [5:0]  OPC_FMTA = 6'b000000;
    localparam logic [5:0]  OPC_B0   = 6'b100010;
    localparam logic [5:0]  OPC_B1   = 6'b100011;
    localparam logic [31:0] NOP_WORD = 32'h0000_003F;

    // Field LSB positions inside the 32-bit word (same map the decoder uses).
    localparam int RS1_LSB    = 27;   // (a),(b)
    localparam int RS2_LSB    = 22;   // (a)
    localparam int RD_A_LSB   = 17;   // (a)
    localparam int RD_B_LSB   = 22;   // (b)
    localparam int IMM_LSB    = 6;    // (b),(c)
    localparam int OPC_LSB    = 0;

    // Returns the first violated rule in priority order, ERR_NONE if legal.
    function automatic err_e check_fields(input logic [1:0]  fmt,
                                          input logic [16:0] opcode,
                                          input logic [31:0] imm,
                                          input logic        extend);
        logic [5:0] op6;
        logic       hi_zero;
        logic       is_b_op;
        logic       reserved;
        logic       b_fits;
        logic       c_fits;
        err_e       result;
        op6      = opcode[5:0];
        hi_zero  = (opcode[16:6] == 11'd0);
        is_b_op  = (op6 == OPC_B0) || (op6 == OPC_B1);
        reserved = is_b_op || (op6 == OPC_NOP);
        // Signed fit: all bits above the top kept bit must match it.
        b_fits   = extend ? ((imm[31:15] == 17'd0) || (imm[31:15] == '1))
                          : (imm[31:16] == 16'd0);
        c_fits   = extend ? ((imm[31:25] == 7'd0) || (imm[31:25] == '1))
                          : (imm[31:26] == 6'd0);
        result   = ERR_NONE;
        case (fmt)
            FMT_A: if (reserved) result = ERR_OPCODE;
            FMT_B: begin
                if (!hi_zero || !is_b_op) result = ERR_OPCODE;
                else if (!b_fits)         result = ERR_RANGE;
            end
            FMT_C: begin
                if (!hi_zero || reserved || (op6 == OPC_FMTA)) result = ERR_OPCODE;
                else if (!c_fits)                              result = ERR_RANGE;
            end
            default: result = ERR_FORMAT;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] pack_word(input logic [1:0]  fmt,
                                              input logic [4:0]  rsrc1,
                                              input logic [4:0]  rsrc2,
                                              input logic [4:0]  rdst,
                                              input logic [16:0] opcode,
                                              input logic [31:0] imm);
        logic [31:0] word;
        case (fmt)
            FMT_A:   word = {rsrc1, rsrc2, rdst, opcode};
            FMT_B:   word = {rsrc1, rdst, imm[15:0], opcode[5:0]};
            FMT_C:   word = {imm[25:0], opcode[5:0]};
            default: word = 32'd0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/encoder_fifo.sv
// Small synchronous FIFO holding {address, word} entries for the loader.
// Ports: clk, rst_n (async low), push/push_data, pop/pop_data (head, zero
// when empty), full, empty, count (registered occupancy).
// Push is ignored when full and pop when empty; the head is read directly
// from storage so a pushed entry is visible the cycle after the push.
module encoder_fifo #(
    parameter int WIDTH      = 40,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == CNT_FULL);
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage needs no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Instruction encoder: accepts field bundles over valid/ready, range-checks
// them, packs legal ones into 32-bit words tagged with an incrementing
// instruction-memory address, and queues them for the loader. A PAD state
// injects runs of NOP words.
// Ports: in_* field bundle + handshake; pad_start/pad_len NOP run request;
// addr_load/addr_value address counter load; out_* queue head + pop;
// err_valid/err_code one-cycle reject report; err_count saturating
// reject count; busy high while padding.
module instruction_encoder
    import instr_fmt_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_format,
    input  logic [4:0]           in_rsrc1,
    input  logic [4:0]           in_rsrc2,
    input  logic [4:0]           in_rdst,
    input  logic [16:0]          in_opcode,
    input  logic [31:0]          in_imm,
    input  logic                 in_extend,
    input  logic                 pad_start,
    input  logic [7:0]           pad_len,
    input  logic                 addr_load,
    input  logic [ADDR_W-1:0]    addr_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_word,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 err_valid,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_PAD = 1'b1} state_e;

    localparam int ENTRY_W = ADDR_W + 32;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = 1;

    state_e                 state_reg, state_next;
    logic [7:0]             pad_rem_reg, pad_rem_next;
    logic [ADDR_W-1:0]      addr_reg;
    logic                   err_valid_reg;
    logic [1:0]             err_code_reg;
    logic [ERR_CNT_W-1:0]   err_count_reg;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [ENTRY_W-1:0]     fifo_head;
    logic [ENTRY_W-1:0]     push_data;

    err_e                   chk;
    logic [31:0]            packed_word;
    logic                   accept;
    logic                   word_push;
    logic                   pad_push;
    logic                   push;

    // Ready is derived from registered occupancy only; rst_n gating keeps it
    // low for the whole reset interval.
    assign in_ready    = rst_n && (state_reg == ST_IDLE) && !fifo_full && !pad_start;
    assign accept      = in_valid && in_ready;
    assign chk         = check_fields(in_format, in_opcode, in_imm, in_extend);
    assign packed_word = pack_word(in_format, in_rsrc1, in_rsrc2, in_rdst, in_opcode, in_imm);
    assign word_push   = accept && (chk == ERR_NONE);
    assign push        = word_push || pad_push;
    assign push_data   = {addr_reg, (pad_push ? NOP_WORD : packed_word)};

    // Next-state logic: one NOP per cycle while the queue has room.
    always_comb begin
        state_next   = state_reg;
        pad_rem_next = pad_rem_reg;
        pad_push     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pad_start && (pad_len != 8'd0)) begin
                    state_next   = ST_PAD;
                    pad_rem_next = pad_len;
                end
            end
            ST_PAD: begin
                if (!fifo_full) begin
                    pad_push     = 1'b1;
                    pad_rem_next = pad_rem_reg - 8'd1;
                    if (pad_rem_reg == 8'd1) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pad_rem_reg   <= 8'd0;
            addr_reg      <= '0;
            err_valid_reg <= 1'b0;
            err_code_reg  <= 2'b00;
            err_count_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pad_rem_reg <= pad_rem_next;
            // A load wins over the increment; the word pushed this cycle
            // already captured the old address.
            if (addr_load)  addr_reg <= addr_value;
            else if (push)  addr_reg <= addr_reg + ADDR_ONE;
            if (accept && (chk != ERR_NONE)) begin
                err_valid_reg <= 1'b1;
                err_code_reg  <= chk;
                if (err_count_reg != '1) err_count_reg <= err_count_reg + ERR_ONE;
            end else begin
                err_valid_reg <= 1'b0;
                err_code_reg  <= 2'b00;
            end
        end
    end

    encoder_fifo #(
        .WIDTH      (ENTRY_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_addr  = fifo_head[ENTRY_W-1:32];
    assign out_word  = fifo_head[31:0];
    assign err_valid = err_valid_reg;
    assign err_code  = err_code_reg;
    assign err_count = err_count_reg;
    assign busy      = (state_reg == ST_PAD);

    // Occupancy is consumed only through full/empty here.
    logic unused_count;
    assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder (default parameters:
// ADDR_W=8, FIFO_DEPTH=2, ERR_CNT_W=8). Inputs change 1 time unit after the
// rising edge; outputs are checked at the same point.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_format;
    logic [4:0]  in_rsrc1, in_rsrc2, in_rdst;
    logic [16:0] in_opcode;
    logic [31:0] in_imm;
    logic        in_extend;
    logic        pad_start;
    logic [7:0]  pad_len;
    logic        addr_load;
    logic [7:0]  addr_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [7:0]  out_addr;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [7:0]  err_count;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    instruction_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_format  (in_format),
        .in_rsrc1   (in_rsrc1),
        .in_rsrc2   (in_rsrc2),
        .in_rdst    (in_rdst),
        .in_opcode  (in_opcode),
        .in_imm     (in_imm),
        .in_extend  (in_extend),
        .pad_start  (pad_start),
        .pad_len    (pad_len),
        .addr_load  (addr_load),
        .addr_value (addr_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_addr   (out_addr),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [4:0] rdst);
        in_format = 2'd0; in_rsrc1 = 5'd3; in_rsrc2 = 5'd7; in_rdst = rdst;
        in_opcode = 17'h00100; in_imm = 32'd0; in_extend = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_format = 2'd0; in_rsrc1 = 5'd0;
        in_rsrc2 = 5'd0; in_rdst = 5'd0; in_opcode = 17'd0; in_imm = 32'd0;
        in_extend = 1'b0; pad_start = 1'b0; pad_len = 8'd0; addr_load = 1'b0;
        addr_value = 8'd0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_word",  out_word,  0);
        check("rst_out_addr",  out_addr,  0);
        check("rst_err_valid", err_valid, 0);
        check("rst_err_code",  err_code,  0);
        check("rst_err_count", err_count, 0);
        check("rst_busy",      busy,      0);
        step(); step();
        rst_n = 1'b1;
        #1 check("ready_after_rst", in_ready, 1);

        // Format (a)
        set_a(5'd9); in_valid = 1'b1;
        #1 check("a_no_early_valid", out_valid, 0);
        step(); in_valid = 1'b0;
        check("a_valid", out_valid, 1);
        check("a_word",  out_word, 32'h19D2_0100);
        check("a_addr",  out_addr, 8'h00);
        step();
        check("a_popped", out_valid, 0);

        // Format (b), signed -1 fits
        in_format = 2'd1; in_rsrc1 = 5'd1; in_rdst = 5'd2; in_imm = 32'hFFFF_FFFF;
        in_extend = 1'b1; in_opcode = 17'h00022; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        check("b_word", out_word, 32'h08BF_FFE2);
        check("b_addr", out_addr, 8'h01);
        check("b_no_err", err_valid, 0);
        step();
        // Same bundle unsigned: out of range
        in_extend = 1'b0; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        check("b_range_err_valid", err_valid, 1);
        check("b_range_err_code",  err_code, 2'b11);
        check("b_range_err_count", err_count, 1);
        check("b_range_no_word",   out_valid, 0);
        step();
        check("err_pulse_one_cycle", err_valid, 0);

        // Bad format then opcode mismatch, back to back
        in_format = 2'd3; in_valid = 1'b1;
        step();
        check("fmt3_code", err_code, 2'b01);
        in_format = 2'd1; in_opcode = 17'h00001; in_extend = 1'b1;
        step(); in_valid = 1'b0;
        check("b_opc_code",  err_code, 2'b10);
        check("b_opc_count", err_count, 3);
        step();
        check("errs_no_word", out_valid, 0);
        set_a(5'd9); in_valid = 1'b1;
        step(); in_valid = 1'b0;
        check("addr_unchanged_by_err", out_addr, 8'h02);
        check("a2_word", out_word, 32'h19D2_0100);
        step();

        // Format (c) with signed imm, and a same-cycle address load
        in_format = 2'd2; in_opcode = 17'h00001; in_imm = 32'hFE00_0000; in_extend = 1'b1;
        addr_load = 1'b1; addr_value = 8'hFE; in_valid = 1'b1;
        step(); in_valid = 1'b0; addr_load = 1'b0;
        check("c_word", out_word, 32'h8000_0001);
        check("c_old_addr", out_addr, 8'h03);
        step();
        in_imm = 32'h0400_0000; in_extend = 1'b0; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        check("c_range_code", err_code, 2'b11);
        check("c_range_count", err_count, 4);
        step();

        // Three streamed words across the address wrap
        in_imm = 32'd5; in_valid = 1'b1;
        step();
        check("wrap_addr0", out_addr, 8'hFE);
        step();
        check("wrap_addr1", out_addr, 8'hFF);
        step(); in_valid = 1'b0;
        check("wrap_addr2", out_addr, 8'h00);
        check("wrap_word",  out_word, 32'h0000_0141);
        step();
        check("wrap_drained", out_valid, 0);

        // Pad run of 3 with a competing bundle
        set_a(5'd9); in_valid = 1'b1; pad_start = 1'b1; pad_len = 8'd3;
        #1 check("pad_refuses_bundle", in_ready, 0);
        step(); pad_start = 1'b0;
        check("pad_busy0", busy, 1);
        check("pad_ready0", in_ready, 0);
        check("pad_nothing_yet", out_valid, 0);
        step();
        check("pad_word1", out_word, 32'h0000_003F);
        check("pad_addr1", out_addr, 8'h01);
        check("pad_busy1", busy, 1);
        step();
        check("pad_addr2", out_addr, 8'h02);
        check("pad_busy2", busy, 1);
        step(); in_valid = 1'b0;
        check("pad_word3", out_word, 32'h0000_003F);
        check("pad_addr3", out_addr, 8'h03);
        check("pad_done_busy", busy, 0);
        check("pad_done_ready", in_ready, 1);
        step();
        check("pad_drained", out_valid, 0);

        // Backpressure: push DEPTH+1 words with consumer stalled
        out_ready = 1'b0; in_format = 2'd0; in_rsrc1 = 5'd0; in_rsrc2 = 5'd0;
        in_opcode = 17'h00100; in_rdst = 5'd1; in_valid = 1'b1;
        step();
        in_rdst = 5'd2;
        check("bp_ready_1", in_ready, 1);
        step();
        in_rdst = 5'd3;
        check("bp_full_ready", in_ready, 0);
        check("bp_head_word", out_word, 32'h0002_0100);
        step();
        check("bp_head_stable", out_word, 32'h0002_0100);
        check("bp_head_addr", out_addr, 8'h04);
        check("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        step();
        check("bp_drain_w2", out_word, 32'h0004_0100);
        check("bp_drain_a2", out_addr, 8'h05);
        step(); in_valid = 1'b0;
        check("bp_drain_w3", out_word, 32'h0006_0100);
        check("bp_drain_a3", out_addr, 8'h06);
        step();
        check("bp_empty", out_valid, 0);

        // Reset in the middle of a stalled pad run
        out_ready = 1'b0; pad_start = 1'b1; pad_len = 8'd5;
        step(); pad_start = 1'b0;
        step(); step(); step();
        check("midpad_busy", busy, 1);
        check("midpad_head", out_addr, 8'h07);
        check("midpad_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_addr", out_addr, 0);
        check("midrst_ready", in_ready, 0);
        step(); rst_n = 1'b1; out_ready = 1'b1;
        #1 check("postrst_ready", in_ready, 1);
        set_a(5'd9); in_valid = 1'b1;
        step(); in_valid = 1'b0;
        check("postrst_addr", out_addr, 8'h00);
        step();

        // Error counter saturation
        in_format = 2'd3; in_valid = 1'b1;
        for (int i = 0; i < 260; i++) step();
        check("sat_count", err_count, 8'hFF);
        check("sat_err_valid", err_valid, 1);
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
